sram_line_mover: RTL and testbench
==================================

# sram_line_mover

Line-transfer sequencer that sits on the controller side of the 8-bank, 128-set two-port cache data array. It owns both array ports and converts two line-level operations into array accesses. Refill takes an 8-beat burst from memory and writes it one bank per beat. Writeback reads a full line in one array access, buffers it, and streams it out as 8 beats with backpressure. Operations are serialized, so array read/write collisions cannot occur.

## Interface
- SET_BITS, 7, set index width (128 sets)
- BANKS, 8, words per line (one word per bank)
- DATA_W, 32, word width
- clock  in  1  sole clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- io_refill_req_valid / io_refill_req_ready  in/out  1  refill request handshake
- io_refill_req_set  in  SET_BITS  target set
- io_refill_beat_valid / io_refill_beat_ready  in/out  1  refill data handshake
- io_refill_beat_data  in  DATA_W  beat word, beat i goes to bank i
- io_refill_beat_last  in  1  sender's end-of-burst marker
- io_wb_req_valid / io_wb_req_ready  in/out  1  writeback request handshake
- io_wb_req_set  in  SET_BITS  source set
- io_wb_beat_valid / io_wb_beat_ready  out/in  1  writeback data handshake
- io_wb_beat_data  out  DATA_W  beat word, beat i from bank i
- io_wb_beat_last  out  1  high on beat 7
- io_sram_r_addr  out  SET_BITS  array read address; data returns the next cycle
- io_sram_r_data_0..7  in  DATA_W  array read data
- io_sram_w_en  out  1  array write enable
- io_sram_w_addr  out  SET_BITS  array write address
- io_sram_w_data_0..7  out  DATA_W  array write data; all lanes carry the current beat word
- io_sram_w_maskOH  out  BANKS  one-hot bank select
- io_busy  out  1  high in any state other than IDLE
- io_err  out  1  one-cycle pulse on a refill last-marker mismatch

## Operation
- States: IDLE, WB_RD, WB_CAP, WB_SEND, REFILL.
- IDLE:
  - Both req_ready are high when not in reset.
  - If both requests are valid, writeback wins; refill_req_ready drops that cycle. This evicts before refilling.
  - An accepted request latches its set into set_reg and clears beat_cnt (3 bits).
- WB_RD: r_addr = set_reg.
- WB_CAP: r_addr is held; all 8 r_data words are captured into line_buf at the end of the cycle.
- WB_SEND:
  - wb_beat_valid = 1, data = line_buf[beat_cnt], last = (beat_cnt == 7).
  - On each handshake beat_cnt increments. The handshake with beat_cnt = 7 returns the FSM to IDLE.
  - Valid and data stay stable while ready is low.
- REFILL:
  - refill_beat_ready = 1.
  - On each handshake (same cycle):
    - w_en = 1, w_addr = set_reg, all w_data lanes = beat_data, maskOH = 1 << beat_cnt.
    - beat_cnt increments.
    - If beat_last != (beat_cnt == 7), io_err pulses the next cycle; the write is still performed.
  - The burst always ends on the 8th handshake. The FSM returns to IDLE regardless of beat_last.
- w_en is 0 outside REFILL handshakes; maskOH = 0 whenever w_en = 0.
- r_addr holds its last value when idle.
- Reset mid-operation: the transfer is abandoned and no further writes are issued. Array contents already written stay as written. The FSM is in IDLE the cycle after reset deasserts.

## Timing
- Reset values:
  - state IDLE, beat_cnt 0, set_reg 0, r_addr 0.
  - All beat valid/ready, w_en, maskOH, io_busy and io_err are 0.
  - Both req_ready are 0 while reset is high.
- Writeback, request accepted at cycle T:
  - WB_RD at T+1, WB_CAP at T+2.
  - First beat valid at T+3; with ready held high, last beat at T+10.
  - IDLE and req_ready high at T+11.
- Refill, request accepted at T: beat_ready high from T+1. With continuous valid, writes occur T+1..T+8 and the FSM is in IDLE at T+9.
- Minimum request-to-request spacing: 11 cycles for writeback, 9 cycles for refill.

## Test plan
- Refill set 0x15 with words 0xA0..0xA7 and last on beat 7. Then writeback set 0x15 with ready held high.
  - 8 writes with maskOH 0x01..0x80 in order.
  - Writeback returns 0xA0..0xA7, last on beat 7 at T+10.
- Writeback with ready toggling 1,0,0,1…
  - Data/valid stable during stalls, no beat dropped or repeated, 8 beats total.
- Refill and writeback requests valid in the same IDLE cycle.
  - Writeback accepted first; refill_req_ready low until writeback completes, then refill accepted.
- Refill where beat_last is asserted on beat 3 and never on beat 7.
  - io_err pulses twice: after beat 3 and after beat 7.
  - All 8 banks are written; FSM returns to IDLE.
- Refill paused with beat_valid low for 5 cycles mid-burst.
  - No w_en during the gap; beat_cnt resumes at the correct bank.
- Reset asserted after refill beat 4.
  - Banks 0..3 hold the new data; banks 4..7 keep their old data.
  - No further w_en; req_ready high on the first cycle after reset deasserts.

Source files
------------

// File: rtl/sram_line_mover_if.sv
// Controller-side bundle for sram_line_mover: refill/writeback handshakes and both
// cache data array ports. slave = the mover, master = the environment driving it.
interface sram_line_mover_if #(
  parameter int unsigned SET_BITS = 7,
  parameter int unsigned DATA_W   = 32
);
  logic                io_refill_req_valid;
  logic                io_refill_req_ready;
  logic [SET_BITS-1:0] io_refill_req_set;
  logic                io_refill_beat_valid;
  logic                io_refill_beat_ready;
  logic [DATA_W-1:0]   io_refill_beat_data;
  logic                io_refill_beat_last;
  logic                io_wb_req_valid;
  logic                io_wb_req_ready;
  logic [SET_BITS-1:0] io_wb_req_set;
  logic                io_wb_beat_valid;
  logic                io_wb_beat_ready;
  logic [DATA_W-1:0]   io_wb_beat_data;
  logic                io_wb_beat_last;
  logic [SET_BITS-1:0] io_sram_r_addr;
  logic [DATA_W-1:0]   io_sram_r_data_0, io_sram_r_data_1, io_sram_r_data_2, io_sram_r_data_3;
  logic [DATA_W-1:0]   io_sram_r_data_4, io_sram_r_data_5, io_sram_r_data_6, io_sram_r_data_7;
  logic                io_sram_w_en;
  logic [SET_BITS-1:0] io_sram_w_addr;
  logic [DATA_W-1:0]   io_sram_w_data_0, io_sram_w_data_1, io_sram_w_data_2, io_sram_w_data_3;
  logic [DATA_W-1:0]   io_sram_w_data_4, io_sram_w_data_5, io_sram_w_data_6, io_sram_w_data_7;
  logic [7:0]          io_sram_w_maskOH;
  logic                io_busy;
  logic                io_err;

  modport slave (
    input  io_refill_req_valid, io_refill_req_set,
    output io_refill_req_ready,
    input  io_refill_beat_valid, io_refill_beat_data, io_refill_beat_last,
    output io_refill_beat_ready,
    input  io_wb_req_valid, io_wb_req_set,
    output io_wb_req_ready,
    output io_wb_beat_valid, io_wb_beat_data, io_wb_beat_last,
    input  io_wb_beat_ready,
    output io_sram_r_addr,
    input  io_sram_r_data_0, io_sram_r_data_1, io_sram_r_data_2, io_sram_r_data_3,
    input  io_sram_r_data_4, io_sram_r_data_5, io_sram_r_data_6, io_sram_r_data_7,
    output io_sram_w_en, io_sram_w_addr, io_sram_w_maskOH,
    output io_sram_w_data_0, io_sram_w_data_1, io_sram_w_data_2, io_sram_w_data_3,
    output io_sram_w_data_4, io_sram_w_data_5, io_sram_w_data_6, io_sram_w_data_7,
    output io_busy, io_err
  );

  modport master (
    output io_refill_req_valid, io_refill_req_set,
    input  io_refill_req_ready,
    output io_refill_beat_valid, io_refill_beat_data, io_refill_beat_last,
    input  io_refill_beat_ready,
    output io_wb_req_valid, io_wb_req_set,
    input  io_wb_req_ready,
    input  io_wb_beat_valid, io_wb_beat_data, io_wb_beat_last,
    output io_wb_beat_ready,
    input  io_sram_r_addr,
    output io_sram_r_data_0, io_sram_r_data_1, io_sram_r_data_2, io_sram_r_data_3,
    output io_sram_r_data_4, io_sram_r_data_5, io_sram_r_data_6, io_sram_r_data_7,
    input  io_sram_w_en, io_sram_w_addr, io_sram_w_maskOH,
    input  io_sram_w_data_0, io_sram_w_data_1, io_sram_w_data_2, io_sram_w_data_3,
    input  io_sram_w_data_4, io_sram_w_data_5, io_sram_w_data_6, io_sram_w_data_7,
    input  io_busy, io_err
  );
endinterface

// File: rtl/sram_line_mover.sv
// Serialised line mover for the 8-bank cache data array: refill writes one bank per
// beat, writeback reads a whole line at once and streams it out with backpressure.
module sram_line_mover #(
  parameter int unsigned SET_BITS = 7,
  parameter int unsigned BANKS    = 8,
  parameter int unsigned DATA_W   = 32
) (
  input logic             clock,
  input logic             reset,
  sram_line_mover_if.slave io
);
  typedef enum logic [2:0] {IDLE, WB_RD, WB_CAP, WB_SEND, REFILL} state_t;

  state_t                        state_q, state_d;
  logic [2:0]                    beat_cnt_q, beat_cnt_d;
  logic [SET_BITS-1:0]           set_q, set_d;
  logic [SET_BITS-1:0]           r_addr_q, r_addr_d;
  logic [BANKS-1:0][DATA_W-1:0]  line_buf_q, line_buf_d;
  logic                          err_q, err_d;

  logic                          idle, wb_acc, rf_acc, wb_hs, rf_hs, cnt_last;
  logic [BANKS-1:0][DATA_W-1:0]  r_line;

  assign r_line = {io.io_sram_r_data_7, io.io_sram_r_data_6, io.io_sram_r_data_5,
                   io.io_sram_r_data_4, io.io_sram_r_data_3, io.io_sram_r_data_2,
                   io.io_sram_r_data_1, io.io_sram_r_data_0};

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      beat_cnt_q <= '0;
      set_q      <= '0;
      r_addr_q   <= '0;
      line_buf_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      set_q      <= set_d;
      r_addr_q   <= r_addr_d;
      line_buf_q <= line_buf_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    set_d      = set_q;
    r_addr_d   = r_addr_q;
    line_buf_d = line_buf_q;

    // Handshake outputs are gated by reset so an abandoned transfer issues no writes.
    idle     = (state_q == IDLE) && !reset;
    cnt_last = (beat_cnt_q == 3'd7);

    io.io_wb_req_ready     = idle;
    io.io_refill_req_ready = idle && !io.io_wb_req_valid;
    wb_acc = io.io_wb_req_ready && io.io_wb_req_valid;
    rf_acc = io.io_refill_req_ready && io.io_refill_req_valid;

    io.io_wb_beat_valid = (state_q == WB_SEND) && !reset;
    io.io_wb_beat_data  = line_buf_q[beat_cnt_q];
    io.io_wb_beat_last  = cnt_last;
    wb_hs = io.io_wb_beat_valid && io.io_wb_beat_ready;

    io.io_refill_beat_ready = (state_q == REFILL) && !reset;
    rf_hs = io.io_refill_beat_ready && io.io_refill_beat_valid;

    io.io_sram_r_addr   = r_addr_q;
    io.io_sram_w_en     = rf_hs;
    io.io_sram_w_addr   = set_q;
    io.io_sram_w_maskOH = rf_hs ? (8'd1 << beat_cnt_q) : '0;
    io.io_sram_w_data_0 = io.io_refill_beat_data;
    io.io_sram_w_data_1 = io.io_refill_beat_data;
    io.io_sram_w_data_2 = io.io_refill_beat_data;
    io.io_sram_w_data_3 = io.io_refill_beat_data;
    io.io_sram_w_data_4 = io.io_refill_beat_data;
    io.io_sram_w_data_5 = io.io_refill_beat_data;
    io.io_sram_w_data_6 = io.io_refill_beat_data;
    io.io_sram_w_data_7 = io.io_refill_beat_data;

    err_d      = rf_hs && (io.io_refill_beat_last != cnt_last);
    io.io_err  = err_q;
    io.io_busy = (state_q != IDLE);

    unique case (state_q)
      IDLE: begin
        // r_addr is loaded on acceptance so the array sees the set during WB_RD.
        if (wb_acc) begin
          set_d      = io.io_wb_req_set;
          r_addr_d   = io.io_wb_req_set;
          beat_cnt_d = '0;
          state_d    = WB_RD;
        end else if (rf_acc) begin
          set_d      = io.io_refill_req_set;
          beat_cnt_d = '0;
          state_d    = REFILL;
        end
      end
      WB_RD:  state_d = WB_CAP;
      WB_CAP: begin
        line_buf_d = r_line;
        state_d    = WB_SEND;
      end
      WB_SEND: begin
        if (wb_hs) begin
          beat_cnt_d = beat_cnt_q + 3'd1;
          if (cnt_last) state_d = IDLE;
        end
      end
      REFILL: begin
        if (rf_hs) begin
          beat_cnt_d = beat_cnt_q + 3'd1;
          if (cnt_last) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_sram_line_mover.sv
// Directed bench for sram_line_mover with a behavioural two-port array model
// (registered read, per-bank masked write).
module tb_sram_line_mover;
  logic clock = 1'b0;
  logic reset;
  logic init_mem;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clock = ~clock;

  sram_line_mover_if #(.SET_BITS(7), .DATA_W(32)) bus ();

  sram_line_mover #(.SET_BITS(7), .BANKS(8), .DATA_W(32)) dut (
    .clock (clock),
    .reset (reset),
    .io    (bus)
  );

  logic [31:0] mem     [128][8];
  logic [31:0] exp_mem [128][8];
  logic [31:0] rd      [8];
  logic [31:0] wd      [8];

  function automatic logic [31:0] old_word(input int unsigned s, input int unsigned b);
    return {16'hD0D0, 1'b0, 7'(s), 8'(b)};
  endfunction

  assign wd[0] = bus.io_sram_w_data_0;
  assign wd[1] = bus.io_sram_w_data_1;
  assign wd[2] = bus.io_sram_w_data_2;
  assign wd[3] = bus.io_sram_w_data_3;
  assign wd[4] = bus.io_sram_w_data_4;
  assign wd[5] = bus.io_sram_w_data_5;
  assign wd[6] = bus.io_sram_w_data_6;
  assign wd[7] = bus.io_sram_w_data_7;
  assign bus.io_sram_r_data_0 = rd[0];
  assign bus.io_sram_r_data_1 = rd[1];
  assign bus.io_sram_r_data_2 = rd[2];
  assign bus.io_sram_r_data_3 = rd[3];
  assign bus.io_sram_r_data_4 = rd[4];
  assign bus.io_sram_r_data_5 = rd[5];
  assign bus.io_sram_r_data_6 = rd[6];
  assign bus.io_sram_r_data_7 = rd[7];

  always @(posedge clock) begin
    for (int b = 0; b < 8; b++) rd[b] <= mem[bus.io_sram_r_addr][b];
    if (init_mem) begin
      for (int s = 0; s < 128; s++)
        for (int b = 0; b < 8; b++) mem[s][b] <= old_word(s, b);
    end else if (bus.io_sram_w_en) begin
      for (int b = 0; b < 8; b++)
        if (bus.io_sram_w_maskOH[b]) mem[bus.io_sram_w_addr][b] <= wd[b];
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  // Refill: optional stall of gap_len cycles before beat gap_at, optional reset after rst_after beats.
  task automatic refill(input logic [6:0] set, input logic [31:0] base, input logic [7:0] last_pat,
                        input int gap_at, input int gap_len, input int rst_after, input bit pre);
    int i = 0;
    int cyc = 0;
    int gap_left = gap_len;
    if (!pre) begin
      bus.io_refill_req_valid = 1'b1;
      bus.io_refill_req_set   = set;
      @(negedge clock);
      check("rf_req_ready", bus.io_refill_req_ready, 1);
      next_cycle();
      bus.io_refill_req_valid = 1'b0;
    end
    while (i < 8 && cyc < 60) begin
      cyc++;
      if (i == gap_at && gap_left > 0) begin
        bus.io_refill_beat_valid = 1'b0;
        @(negedge clock);
        check("rf_gap_wen", bus.io_sram_w_en, 0);
        check("rf_gap_mask", bus.io_sram_w_maskOH, 0);
        check("rf_gap_ready", bus.io_refill_beat_ready, 1);
        next_cycle();
        gap_left--;
        continue;
      end
      bus.io_refill_beat_valid = 1'b1;
      bus.io_refill_beat_data  = base + 32'(i);
      bus.io_refill_beat_last  = last_pat[i];
      @(negedge clock);
      check("rf_beat_ready", bus.io_refill_beat_ready, 1);
      check("rf_wen", bus.io_sram_w_en, 1);
      check("rf_mask", bus.io_sram_w_maskOH, 64'(1) << i);
      check("rf_waddr", bus.io_sram_w_addr, set);
      check("rf_wdata0", bus.io_sram_w_data_0, base + 32'(i));
      check("rf_wdata7", bus.io_sram_w_data_7, base + 32'(i));
      check("rf_busy", bus.io_busy, 1);
      next_cycle();
      exp_mem[set][i] = base + 32'(i);
      check("rf_err", bus.io_err, {63'd0, last_pat[i] != (i == 7)});
      i++;
      if (i == rst_after) begin
        reset = 1'b1;
        bus.io_refill_beat_valid = 1'b1;
        bus.io_refill_beat_data  = base + 32'(i);
        bus.io_refill_beat_last  = 1'b0;
        @(negedge clock);
        check("rst_wen", bus.io_sram_w_en, 0);
        check("rst_beat_ready", bus.io_refill_beat_ready, 0);
        check("rst_wb_req_ready", bus.io_wb_req_ready, 0);
        next_cycle();
        reset = 1'b0;
        bus.io_refill_beat_valid = 1'b0;
        @(negedge clock);
        check("rst_busy", bus.io_busy, 0);
        check("rst_wb_ready_after", bus.io_wb_req_ready, 1);
        check("rst_rf_ready_after", bus.io_refill_req_ready, 1);
        check("rst_wen_after", bus.io_sram_w_en, 0);
        next_cycle();
        return;
      end
    end
    check("rf_beats", 64'(i), 8);
    bus.io_refill_beat_valid = 1'b0;
    bus.io_refill_beat_last  = 1'b0;
    @(negedge clock);
    check("rf_done_busy", bus.io_busy, 0);
    check("rf_done_ready", bus.io_refill_req_ready, 1);
    check("rf_done_wen", bus.io_sram_w_en, 0);
    next_cycle();
  endtask

  // Writeback: ready follows rdy_pat[k%4]; pend keeps a refill request waiting behind it.
  task automatic writeback(input logic [6:0] set, input logic [3:0] rdy_pat, input bit pend);
    int i = 0;
    int k = 0;
    bus.io_wb_req_valid = 1'b1;
    bus.io_wb_req_set   = set;
    @(negedge clock);
    check("wb_req_ready", bus.io_wb_req_ready, 1);
    if (pend) check("arb_rf_ready_low", bus.io_refill_req_ready, 0);
    next_cycle();
    bus.io_wb_req_valid = 1'b0;
    @(negedge clock);
    check("wb_rd_raddr", bus.io_sram_r_addr, set);
    check("wb_rd_valid", bus.io_wb_beat_valid, 0);
    check("wb_rd_busy", bus.io_busy, 1);
    next_cycle();
    @(negedge clock);
    check("wb_cap_raddr", bus.io_sram_r_addr, set);
    check("wb_cap_valid", bus.io_wb_beat_valid, 0);
    next_cycle();
    while (i < 8 && k < 60) begin
      bus.io_wb_beat_ready = rdy_pat[k % 4];
      @(negedge clock);
      check("wb_valid", bus.io_wb_beat_valid, 1);
      check("wb_data", bus.io_wb_beat_data, exp_mem[set][i]);
      check("wb_last", bus.io_wb_beat_last, {63'd0, i == 7});
      check("wb_wen", bus.io_sram_w_en, 0);
      check("wb_rf_ready", bus.io_refill_req_ready, 0);
      next_cycle();
      if (rdy_pat[k % 4]) i++;
      k++;
    end
    check("wb_beats", 64'(i), 8);
    if (rdy_pat == 4'hF) check("wb_cycles", 64'(k), 8);
    bus.io_wb_beat_ready = 1'b0;
    @(negedge clock);
    check("wb_done_busy", bus.io_busy, 0);
    check("wb_done_ready", bus.io_wb_req_ready, 1);
    if (pend) check("arb_rf_accept", bus.io_refill_req_ready, 1);
    next_cycle();
    if (pend) bus.io_refill_req_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int s = 0; s < 128; s++)
      for (int b = 0; b < 8; b++) exp_mem[s][b] = old_word(s, b);
    reset = 1'b1;
    init_mem = 1'b1;
    bus.io_refill_req_valid  = 1'b0;
    bus.io_refill_req_set    = '0;
    bus.io_refill_beat_valid = 1'b0;
    bus.io_refill_beat_data  = '0;
    bus.io_refill_beat_last  = 1'b0;
    bus.io_wb_req_valid      = 1'b0;
    bus.io_wb_req_set        = '0;
    bus.io_wb_beat_ready     = 1'b0;
    repeat (2) next_cycle();
    init_mem = 1'b0;
    @(negedge clock);
    check("rst_wb_req_ready", bus.io_wb_req_ready, 0);
    check("rst_rf_req_ready", bus.io_refill_req_ready, 0);
    check("rst_busy", bus.io_busy, 0);
    check("rst_wen", bus.io_sram_w_en, 0);
    check("rst_mask", bus.io_sram_w_maskOH, 0);
    check("rst_raddr", bus.io_sram_r_addr, 0);
    check("rst_err", bus.io_err, 0);
    check("rst_wb_valid", bus.io_wb_beat_valid, 0);
    check("rst_rf_beat_ready", bus.io_refill_beat_ready, 0);
    next_cycle();
    reset = 1'b0;
    @(negedge clock);
    check("idle_wb_req_ready", bus.io_wb_req_ready, 1);
    check("idle_rf_req_ready", bus.io_refill_req_ready, 1);
    next_cycle();

    refill(7'h15, 32'hA0, 8'h80, -1, 0, -1, 1'b0);
    writeback(7'h15, 4'b1111, 1'b0);

    refill(7'h33, 32'hB0, 8'h08, -1, 0, -1, 1'b0);
    writeback(7'h33, 4'b1001, 1'b0);

    refill(7'h40, 32'hC0, 8'h80, 3, 5, -1, 1'b0);
    writeback(7'h40, 4'b1111, 1'b0);

    bus.io_refill_req_valid = 1'b1;
    bus.io_refill_req_set   = 7'h51;
    writeback(7'h15, 4'b1111, 1'b1);
    refill(7'h51, 32'hD0, 8'h80, -1, 0, -1, 1'b1);
    writeback(7'h51, 4'b1111, 1'b0);

    refill(7'h22, 32'hE0, 8'h80, -1, 0, 4, 1'b0);
    writeback(7'h22, 4'b1111, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
